// File: rtl/port_b_arbiter.sv
// Port-B arbiter for duel_ram: round-robin between CPU and debug/loader,
// with a bounded burst lock for the debug requester and a 1-cycle read return.
module port_b_arbiter #(
  parameter int unsigned MAX_LOCK = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [10:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  output logic [31:0] cpu_rdata,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [10:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  input  logic        dbg_lock,
  output logic        dbg_gnt,
  output logic        dbg_rvalid,
  output logic [31:0] dbg_rdata,
  output logic [10:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic        ram_wren,
  input  logic [31:0] ram_q
);

  typedef enum logic {ARB, LOCKED} state_e;

  localparam logic [7:0] MAX_LOCK_C = 8'(MAX_LOCK);

  state_e     state_q, state_d;
  logic       last_dbg_q, last_dbg_d;   // 1: debug held the most recent grant
  logic [7:0] lock_cnt_q, lock_cnt_d;
  logic [7:0] lock_inc;
  logic       cpu_rv_q, dbg_rv_q;

  always_comb begin
    cpu_gnt    = 1'b0;
    dbg_gnt    = 1'b0;
    state_d    = state_q;
    last_dbg_d = last_dbg_q;
    lock_cnt_d = lock_cnt_q;
    lock_inc   = lock_cnt_q + 8'd1;
    if (!rst) begin
      case (state_q)
        ARB: begin
          if (cpu_req && dbg_req) begin
            cpu_gnt = last_dbg_q;
            dbg_gnt = ~last_dbg_q;
          end else begin
            cpu_gnt = cpu_req;
            dbg_gnt = dbg_req;
          end
          // Lock only takes effect once debug has actually won arbitration.
          if (dbg_gnt && dbg_lock && (MAX_LOCK > 1)) begin
            state_d    = LOCKED;
            lock_cnt_d = 8'd1;
          end
        end
        LOCKED: begin
          if (dbg_req) begin
            dbg_gnt = 1'b1;
            if (!dbg_lock || (lock_inc >= MAX_LOCK_C)) begin
              state_d    = ARB;
              lock_cnt_d = 8'd0;
            end else begin
              lock_cnt_d = lock_inc;
            end
          end else begin
            cpu_gnt    = cpu_req;
            state_d    = ARB;
            lock_cnt_d = 8'd0;
          end
        end
        default: begin
          state_d    = ARB;
          lock_cnt_d = 8'd0;
        end
      endcase
      if (cpu_gnt)      last_dbg_d = 1'b0;
      else if (dbg_gnt) last_dbg_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARB;
      last_dbg_q <= 1'b1;
      lock_cnt_q <= 8'd0;
      cpu_rv_q   <= 1'b0;
      dbg_rv_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_dbg_q <= last_dbg_d;
      lock_cnt_q <= lock_cnt_d;
      cpu_rv_q   <= cpu_gnt & ~cpu_we;
      dbg_rv_q   <= dbg_gnt & ~dbg_we;
    end
  end

  assign ram_addr  = cpu_gnt ? cpu_addr  : (dbg_gnt ? dbg_addr  : 11'd0);
  assign ram_wdata = cpu_gnt ? cpu_wdata : (dbg_gnt ? dbg_wdata : 32'd0);
  assign ram_wren  = (cpu_gnt & cpu_we) | (dbg_gnt & dbg_we);

  // Reset in the return cycle kills a read that was already in flight.
  assign cpu_rvalid = cpu_rv_q & ~rst;
  assign dbg_rvalid = dbg_rv_q & ~rst;
  assign cpu_rdata  = ram_q;
  assign dbg_rdata  = ram_q;

endmodule

// File: tb/tb_port_b_arbiter.sv
// Directed bench for port_b_arbiter with a behavioural port-B RAM and a
// read-return scoreboard.
module tb_port_b_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [10:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic        cpu_gnt, cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        dbg_req = 1'b0, dbg_we = 1'b0, dbg_lock = 1'b0;
  logic [10:0] dbg_addr = '0;
  logic [31:0] dbg_wdata = '0;
  logic        dbg_gnt, dbg_rvalid;
  logic [31:0] dbg_rdata;
  logic [10:0] ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_wren;
  logic [31:0] ram_q;

  port_b_arbiter #(.MAX_LOCK(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_lock(dbg_lock), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wren(ram_wren), .ram_q(ram_q)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:2047];
  always @(posedge clk) begin
    if (ram_wren) mem[ram_addr] <= ram_wdata;
    ram_q <= mem[ram_addr];
  end

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  typedef struct {
    bit          is_dbg;
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t sb[$];

  logic [31:0] shadow [0:2047];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("%s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One arbitration cycle: drive, check grants and RAM port, record reads.
  task automatic step(input logic cr, input logic cw, input logic [10:0] ca, input logic [31:0] cd,
                      input logic dr, input logic dw, input logic [10:0] da, input logic [31:0] dd,
                      input logic dl, input logic ec, input logic ed, input string tag);
    exp_t e;
    @(negedge clk);
    rst = 1'b0;
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dbg_req = dr; dbg_we = dw; dbg_addr = da; dbg_wdata = dd; dbg_lock = dl;
    #1;
    chk({tag, ".cpu_gnt"}, 32'(cpu_gnt), 32'(ec));
    chk({tag, ".dbg_gnt"}, 32'(dbg_gnt), 32'(ed));
    chk({tag, ".ram_addr"}, 32'(ram_addr), ec ? 32'(ca) : (ed ? 32'(da) : 32'd0));
    chk({tag, ".ram_wdata"}, ram_wdata, ec ? cd : (ed ? dd : 32'd0));
    chk({tag, ".ram_wren"}, 32'(ram_wren), 32'((ec & cw) | (ed & dw)));
    if (ec && cw) shadow[ca] = cd;
    if (ed && dw) shadow[da] = dd;
    if (ec && !cw) begin e.is_dbg = 1'b0; e.data = shadow[ca]; e.due = cyc_cnt + 1; sb.push_back(e); end
    if (ed && !dw) begin e.is_dbg = 1'b1; e.data = shadow[da]; e.due = cyc_cnt + 1; sb.push_back(e); end
  endtask

  // Reset cycle with every requester active: nothing may reach the RAM.
  task automatic do_rst(input string tag);
    @(negedge clk);
    rst = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 11'h7ff; cpu_wdata = 32'hffff_ffff;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 11'h7fe; dbg_wdata = 32'h5555_5555; dbg_lock = 1'b1;
    #1;
    chk({tag, ".cpu_gnt"}, 32'(cpu_gnt), 32'd0);
    chk({tag, ".dbg_gnt"}, 32'(dbg_gnt), 32'd0);
    chk({tag, ".ram_addr"}, 32'(ram_addr), 32'd0);
    chk({tag, ".ram_wdata"}, ram_wdata, 32'd0);
    chk({tag, ".ram_wren"}, 32'(ram_wren), 32'd0);
    sb.delete();
  endtask

  // Read-return monitor: each cycle, rvalid must match the scoreboard head.
  initial begin
    logic ev_c, ev_d;
    forever begin
      @(negedge clk);
      #2;
      ev_c = 1'b0;
      ev_d = 1'b0;
      if (sb.size() > 0 && sb[0].due == cyc_cnt) begin
        ev_c = !sb[0].is_dbg;
        ev_d = sb[0].is_dbg;
      end
      chk("cpu_rvalid", 32'(cpu_rvalid), 32'(ev_c));
      chk("dbg_rvalid", 32'(dbg_rvalid), 32'(ev_d));
      if (ev_c) chk("cpu_rdata", cpu_rdata, sb[0].data);
      if (ev_d) chk("dbg_rdata", dbg_rdata, sb[0].data);
      while (sb.size() > 0 && sb[0].due <= cyc_cnt) void'(sb.pop_front());
    end
  end

  localparam logic [10:0] CA = 11'h005;
  localparam logic [10:0] DA = 11'h010;

  initial begin
    do_rst("rst_a");
    do_rst("rst_b");
    // Single writes, then CPU read-back
    step(1, 1, CA, 32'hDEADBEEF, 0, 0, DA, 32'h0, 0, 1, 0, "wr_cpu");
    step(0, 0, CA, 32'h0, 1, 1, DA, 32'h12345678, 0, 0, 1, "wr_dbg");
    step(1, 0, CA, 32'h0, 0, 0, DA, 32'h0, 0, 1, 0, "rd_cpu");
    // Round-robin after reset: CPU wins the first tie
    do_rst("rst_c");
    step(1, 0, CA, 32'h0, 1, 0, DA, 32'h0, 0, 1, 0, "rr0");
    step(1, 0, CA, 32'h0, 1, 0, DA, 32'h0, 0, 0, 1, "rr1");
    step(1, 0, CA, 32'h0, 1, 0, DA, 32'h0, 0, 1, 0, "rr2");
    step(1, 0, CA, 32'h0, 1, 0, DA, 32'h0, 0, 0, 1, "rr3");
    // Lock is subject to round-robin, then capped at 4 beats
    step(1, 0, CA, 32'h0, 1, 0, DA, 32'h0, 1, 1, 0, "lk0");
    step(1, 0, CA, 32'h0, 1, 0, DA, 32'h0, 1, 0, 1, "lk1");
    step(1, 0, CA, 32'h0, 1, 0, DA, 32'h0, 1, 0, 1, "lk2");
    step(1, 0, CA, 32'h0, 1, 0, DA, 32'h0, 1, 0, 1, "lk3");
    step(1, 0, CA, 32'h0, 1, 0, DA, 32'h0, 1, 0, 1, "lk4");
    step(1, 0, CA, 32'h0, 1, 0, DA, 32'h0, 1, 1, 0, "lk5");
    step(1, 0, CA, 32'h0, 1, 0, DA, 32'h0, 1, 0, 1, "lk6");
    step(1, 0, CA, 32'h0, 0, 0, DA, 32'h0, 1, 1, 0, "lk_rel");
    // Lock dropped on beat 2
    step(1, 0, CA, 32'h0, 1, 0, DA, 32'h0, 1, 0, 1, "dr1");
    step(1, 0, CA, 32'h0, 1, 0, DA, 32'h0, 0, 0, 1, "dr2");
    step(1, 0, CA, 32'h0, 1, 0, DA, 32'h0, 0, 1, 0, "dr3");
    // Reset mid-burst with a debug read in flight
    step(1, 0, CA, 32'h0, 1, 0, DA, 32'h0, 1, 0, 1, "rs1");
    step(1, 0, CA, 32'h0, 1, 0, DA, 32'h0, 1, 0, 1, "rs2");
    do_rst("rs_rst");
    step(1, 0, CA, 32'h0, 1, 0, DA, 32'h0, 1, 1, 0, "rs3");
    step(1, 0, CA, 32'h0, 1, 0, DA, 32'h0, 1, 0, 1, "rs4");
    step(1, 0, CA, 32'h0, 0, 0, DA, 32'h0, 1, 1, 0, "rs5");
    // Back-to-back CPU reads, then idle
    step(1, 0, CA, 32'h0, 0, 0, DA, 32'h0, 0, 1, 0, "b2b0");
    step(1, 0, CA, 32'h0, 0, 0, DA, 32'h0, 0, 1, 0, "b2b1");
    step(1, 0, CA, 32'h0, 0, 0, DA, 32'h0, 0, 1, 0, "b2b2");
    step(0, 0, CA, 32'h0, 0, 0, DA, 32'h0, 0, 0, 0, "idle0");
    step(0, 0, CA, 32'h0, 0, 0, DA, 32'h0, 1, 0, 0, "idle1");
    @(negedge clk);
    #3;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/port_b_arbiter.md
PORT_B_ARBITER -- requirements
Module: port_b_arbiter

Interface
REQ-001 SHALL have parameter MAX_LOCK, default 16: maximum consecutive locked debug beats before forced release; legal range 1..255.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port cpu_req  in  1  CPU requests a port-B access this cycle.
REQ-005 SHALL have port cpu_we  in  1  1 = write, 0 = read.
REQ-006 SHALL have port cpu_addr  in  11  CPU word address.
REQ-007 SHALL have port cpu_wdata  in  32  CPU write data.
REQ-008 SHALL have port cpu_gnt  out  1  CPU access issued to RAM this cycle.
REQ-009 SHALL have port cpu_rvalid  out  1  CPU read data valid.
REQ-010 SHALL have port cpu_rdata  out  32  CPU read data.
REQ-011 SHALL have ports dbg_req, dbg_we, dbg_addr (11), dbg_wdata (32), dbg_gnt, dbg_rvalid, dbg_rdata (32), same directions and meanings as the CPU set, for the debug/loader requester.
REQ-012 SHALL have port dbg_lock  in  1  debug requests burst ownership of port B.
REQ-013 SHALL have ports ram_addr  out  11, ram_wdata  out  32, ram_wren  out  1  to duel_ram port B.
REQ-014 SHALL have port ram_q  in  32  duel_ram port-B read data, valid one cycle after address presented.

Function
REQ-015 SHALL assert at most one of cpu_gnt/dbg_gnt per cycle; gnt is combinational from req and registered state, same cycle as req.
REQ-016 SHALL never assert a gnt whose req is low; SHALL assert one gnt whenever any req is high and rst is low.
REQ-017 SHALL drive ram_addr/ram_wdata from the granted requester, ram_wren = granted requester's we; no grant: ram_addr=0, ram_wdata=0, ram_wren=0.
REQ-018 SHALL assert the requester's rvalid exactly one cycle after a granted read (we=0), never after a write.
REQ-019 SHALL drive cpu_rdata and dbg_rdata directly from ram_q; content meaningful only when the matching rvalid=1.
REQ-020 SHALL implement FSM states ARB and LOCKED plus registers last_gnt (CPU/DBG) and lock_cnt (8 bits).
REQ-021 In ARB: single requester wins; both requesting: requester other than last_gnt wins (round-robin); last_gnt updates to the winner on every grant.
REQ-022 In ARB: dbg granted with dbg_lock=1 and MAX_LOCK>1 -> LOCKED, lock_cnt=1; with MAX_LOCK=1 stay ARB.
REQ-023 In LOCKED: dbg_req=1 -> dbg granted regardless of cpu_req; each grant increments lock_cnt.
REQ-024 LOCKED -> ARB when: dbg_req=0 (CPU may be granted same cycle), or dbg granted with dbg_lock=0 (final beat), or granted beat makes lock_cnt reach MAX_LOCK; lock_cnt cleared on exit.
REQ-025 On forced release (MAX_LOCK reached) last_gnt=DBG, so a waiting CPU wins the next contended cycle; debug may re-lock only after a new ARB win.
REQ-026 Simultaneous: cpu_req and dbg_req with dbg_lock in ARB obey round-robin first; lock applies only once dbg actually wins.
REQ-027 Back-to-back grants to the same requester SHALL be allowed every cycle; rvalid pipeline SHALL sustain one read per cycle.

Reset
REQ-028 While rst=1: cpu_gnt=dbg_gnt=0, ram_wren=0, ram_addr=0, ram_wdata=0, regardless of req.
REQ-029 On a rst=1 edge: state=ARB, last_gnt=DBG (CPU wins first tie), lock_cnt=0, cpu_rvalid=dbg_rvalid=0.
REQ-030 Reset mid-burst or with a read in flight SHALL drop the lock and suppress the pending rvalid on the following cycle.

Verification
REQ-031 Both req every cycle, no lock, after reset -> grants alternate CPU, DBG, CPU, DBG; rvalid follows each read by one cycle.
REQ-032 CPU write addr 0x005 data 0xDEADBEEF, then CPU read 0x005 -> ram_wren=1 only on write; cpu_rvalid next cycle with cpu_rdata=0xDEADBEEF.
REQ-033 MAX_LOCK=4, dbg_req+dbg_lock held, cpu_req held -> dbg granted 4 consecutive cycles, CPU granted 5th, dbg 6th.
REQ-034 Locked burst, dbg_lock dropped on beat 2 -> beat 2 granted to dbg, cycle 3 grant to CPU; lock_cnt=0.
REQ-035 rst pulsed during LOCKED with dbg read in flight -> no dbg_rvalid next cycle, no grants during rst, first tie after reset goes to CPU.
